axi_lite_cmd_master: RTL and testbench
======================================

// Module: axi_lite_cmd_master
// PURPOSE
//  Single-outstanding AXI4-Lite initiator. Turns a simple cmd/rsp valid-ready command stream
//  (write or read of one 32-bit register) into AXI4-Lite master transactions.
//  Drives the traffic generator/checker register slaves from an on-chip sequencer or debug bridge.
//  Includes a per-transaction timeout so a dead slave never hangs the sequencer.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  12          AXI address width
//  C_M_AXI_DATA_WIDTH  32          AXI data width (only 32 supported)
//  C_BASE_ADDRESS      32'h0       XORed onto cmd_addr to form AWADDR/ARADDR
//  C_TIMEOUT_CYCLES    256         cycles allowed per transaction, counted from AXI issue (>=2)
// PORTS
//  clk            in   1      single clock for all logic
//  reset          in   1      asynchronous, active-high reset
//  cmd_valid      in   1      command present
//  cmd_ready      out  1      command accepted when cmd_valid & cmd_ready
//  cmd_write      in   1      1 = write, 0 = read
//  cmd_addr       in   AW     register offset
//  cmd_wdata      in   32     write data
//  cmd_wstrb      in   4      write strobes (pass-through)
//  rsp_valid      out  1      response present; held until rsp_ready
//  rsp_ready      in   1      response consumed
//  rsp_rdata      out  32     read data (0 for writes)
//  rsp_resp       out  2      BRESP/RRESP; 2'b10 on timeout
//  rsp_timeout    out  1      1 = transaction timed out
//  M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY,
//  M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY   standard AXI4-Lite master
// BEHAVIOUR
//  Reset (async, any time incl. mid-transaction): state=IDLE; all VALID/READY outputs, rsp_valid,
//   rsp_timeout = 0; rsp_rdata, rsp_resp, AxADDR, WDATA, WSTRB = 0; timeout counter = 0.
//  All outputs registered. cmd_ready = (state==IDLE), only one transaction in flight.
//  FSM: IDLE -> WR_ADDR_DATA (cmd_write) | RD_ADDR (!cmd_write) on cmd accept; command fields
//   latched, AxADDR = cmd_addr ^ C_BASE_ADDRESS[AW-1:0], AW/ARVALID high cycle after accept.
//  WR_ADDR_DATA: AWVALID and WVALID raised in the same cycle; each drops the cycle after its own
//   READY is seen (independent handshakes; slave may accept in either order or together).
//   When both accepted -> WR_RESP. BREADY=1 in WR_RESP; BVALID -> RSP, latch BRESP, rdata=0.
//   A BVALID arriving while AW/W still pending is held off (BREADY=0 until both accepted).
//  RD_ADDR: ARVALID held until ARREADY -> RD_DATA. RREADY=1 in RD_DATA; RVALID -> RSP,
//   latch RDATA/RRESP.
//  RSP: rsp_valid=1, fields stable until rsp_valid & rsp_ready -> IDLE. cmd_ready rises the
//   cycle after the response handshake (no same-cycle rsp/cmd overlap).
//  Minimum latency with an immediate-ready slave: accept cycle N, AxVALID N+1, rsp_valid N+3.
//  VALID never depends combinationally on READY; AxADDR/WDATA stable while VALID high.
//  Timeout: counter cleared on cmd accept, increments each cycle in WR_*/RD_* states; reaching
//   C_TIMEOUT_CYCLES -> all AXI valids/readies forced 0, state RSP, rsp_resp=2'b10,
//   rsp_timeout=1, rsp_rdata=0. Completion and expiry in the same cycle: completion wins.
//   Abandoning VALID on timeout is a deliberate recovery breach; a late B/R from that slave is
//   ignored since READY is 0 outside WR_RESP/RD_DATA.
//  Counter width clog2(C_TIMEOUT_CYCLES)+1; no wrap possible.
// TESTING
//  1 Write 0x10=0xA5A5_0001 vs slave (AW/W ready same cycle, BRESP=0) -> one AW+W beat,
//    AWADDR=0x010, rsp_valid 3 cycles after accept, rsp_resp=0, rsp_timeout=0.
//  2 Read 0x00 vs slave returning 0x0000_CAFE after 5 RVALID-wait cycles -> rsp_rdata=0xCAFE,
//    rsp_resp=0; ARVALID dropped after single ARREADY.
//  3 Slave WREADY 4 cycles after AWREADY -> AWVALID low after its handshake, WVALID held,
//    BREADY only after W accepted; exactly one write reaches slave.
//  4 Read to non-responding slave, C_TIMEOUT_CYCLES=16 -> ARVALID drops after 16 cycles,
//    rsp_resp=2'b10, rsp_timeout=1, cmd_ready returns after rsp handshake.
//  5 rsp_ready held low 10 cycles, then back-to-back cmds -> rsp fields stable, cmd_ready=0
//    throughout, second cmd accepted cycle after rsp handshake; C_BASE_ADDRESS=0x800 ->
//    AWADDR=0x810.
//  6 Assert reset while WR_RESP pending -> all valids 0 immediately (async), cmd_ready=1 first
//    edge after release, stale BVALID not accepted.

Source files
------------

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle shared by the command master and the register slave it drives.
interface axi_lite_cmd_master_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one cmd/rsp transaction at a time, with a
// per-transaction timeout so an unresponsive slave cannot stall the command stream.
module axi_lite_cmd_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 12,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_BASE_ADDRESS     = 32'h0,
  parameter int unsigned C_TIMEOUT_CYCLES   = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  axi_lite_cmd_master_if.master           m_axi
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(C_TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(C_TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] BASE     = C_BASE_ADDRESS[AW-1:0];
  localparam logic [1:0]    RESP_TO  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_t;

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic accept;
  logic busy;
  logic expire;
  logic timeout_hit;
  logic aw_done;
  logic w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    timeout_hit   = 1'b0;

    accept  = cmd_valid & cmd_ready_q;
    busy    = (state_q == S_WR_ADDR_DATA) || (state_q == S_WR_RESP) ||
              (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
    expire  = busy && (cnt_q == CNT_LAST);
    aw_done = !awvalid_q || m_axi.awready;
    w_done  = !wvalid_q || m_axi.wready;

    if (busy) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (cmd_write) begin
            state_d   = S_WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr ^ BASE;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr ^ BASE;
          end
        end
      end

      // AW and W complete independently; B is only accepted once both are gone.
      S_WR_ADDR_DATA: begin
        if (expire) begin
          timeout_hit = 1'b1;
        end else begin
          if (m_axi.awready) awvalid_d = 1'b0;
          if (m_axi.wready)  wvalid_d  = 1'b0;
          if (aw_done && w_done) begin
            state_d  = S_WR_RESP;
            bready_d = 1'b1;
          end
        end
      end

      S_WR_RESP: begin
        if (m_axi.bvalid) begin
          state_d       = S_RSP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi.bresp;
          rsp_timeout_d = 1'b0;
        end else if (expire) begin
          timeout_hit = 1'b1;
        end
      end

      S_RD_ADDR: begin
        if (expire) begin
          timeout_hit = 1'b1;
        end else if (m_axi.arready) begin
          state_d   = S_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end

      S_RD_DATA: begin
        if (m_axi.rvalid) begin
          state_d       = S_RSP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_axi.rdata;
          rsp_resp_d    = m_axi.rresp;
          rsp_timeout_d = 1'b0;
        end else if (expire) begin
          timeout_hit = 1'b1;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abandon the bus; any late B/R is ignored because READY stays low afterwards.
    if (timeout_hit) begin
      state_d       = S_RSP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_TO;
      rsp_timeout_d = 1'b1;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: directed commands against a configurable slave model,
// responses checked by a scoreboard monitor.
module tb_axi_lite_cmd_master;

  localparam int AW = 12;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  axi_lite_cmd_master_if #(.ADDR_W(AW), .DATA_W(32)) axi ();

  axi_lite_cmd_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(32),
    .C_BASE_ADDRESS    (32'h0000_0800),
    .C_TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_axi      (axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  // Slave configuration and observation
  int          cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  logic        slv_clear = 1'b0;
  int          aw_beats = 0, w_beats = 0, ar_beats = 0;
  int          n_awv = 0, n_wv = 0, n_arv = 0, n_bviol = 0, n_brdy = 0, n_bvld = 0;
  logic [AW-1:0] got_awaddr = '0, got_araddr = '0;
  logic [31:0] got_wdata = '0;
  logic [3:0]  got_wstrb = '0;

  initial begin : slave
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic aw_got, w_got, b_pend, r_pend;
    logic p_aw_hs, p_w_hs, p_b_hs, p_ar_hs, p_r_hs;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    p_aw_hs = 0; p_w_hs = 0; p_b_hs = 0; p_ar_hs = 0; p_r_hs = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    forever begin
      @(negedge clk);
      if (slv_clear) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        p_aw_hs = 0; p_w_hs = 0; p_b_hs = 0; p_ar_hs = 0; p_r_hs = 0;
        slv_clear = 0;
      end
      if (p_aw_hs) begin aw_beats++; got_awaddr = p_awaddr; aw_got = 1; aw_wait = 0; end
      if (p_w_hs)  begin w_beats++; got_wdata = p_wdata; got_wstrb = p_wstrb; w_got = 1; w_wait = 0; end
      if (p_b_hs)  b_pend = 0;
      if (p_ar_hs) begin ar_beats++; got_araddr = p_araddr; r_pend = 1; r_wait = 0; ar_wait = 0; end
      if (p_r_hs)  r_pend = 0;
      if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end

      if (axi.awvalid) n_awv++;
      if (axi.wvalid)  n_wv++;
      if (axi.arvalid) n_arv++;
      if (axi.bready && (axi.awvalid || axi.wvalid)) n_bviol++;
      if (axi.bready) n_brdy++;

      aw_wait = axi.awvalid ? aw_wait + 1 : 0;
      w_wait  = axi.wvalid  ? w_wait + 1  : 0;
      ar_wait = axi.arvalid ? ar_wait + 1 : 0;
      if (b_pend) b_wait++;
      if (r_pend) r_wait++;
      axi.awready = axi.awvalid && (aw_wait > cfg_aw_d);
      axi.wready  = axi.wvalid  && (w_wait > cfg_w_d);
      axi.arready = axi.arvalid && (ar_wait > cfg_ar_d);
      axi.bvalid  = b_pend && (b_wait > cfg_b_d);
      axi.bresp   = cfg_bresp;
      axi.rvalid  = r_pend && (r_wait > cfg_r_d);
      axi.rdata   = axi.rvalid ? cfg_rdata : 32'h0;
      axi.rresp   = cfg_rresp;
      if (axi.bvalid) n_bvld++;

      p_aw_hs = axi.awvalid && axi.awready;
      p_w_hs  = axi.wvalid && axi.wready;
      p_b_hs  = axi.bvalid && axi.bready;
      p_ar_hs = axi.arvalid && axi.arready;
      p_r_hs  = axi.rvalid && axi.rready;
      p_awaddr = axi.awaddr; p_araddr = axi.araddr;
      p_wdata  = axi.wdata;  p_wstrb  = axi.wstrb;
    end
  end

  // Scoreboard monitor
  int last_hs = -100;
  initial begin : monitor
    logic seen, chk_cr;
    int first_cyc, unstable;
    logic [34:0] snap;
    exp_t e;
    seen = 0; chk_cr = 0; first_cyc = 0; unstable = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 0; chk_cr = 0;
      end else begin
        if (chk_cr) begin
          chk("cmd_ready_after_rsp", cmd_ready, 1);
          chk_cr = 0;
        end
        if (rsp_valid) begin
          if (!seen) begin
            seen = 1; first_cyc = cyc; unstable = 0;
            snap = {rsp_rdata, rsp_resp, rsp_timeout};
          end else if ({rsp_rdata, rsp_resp, rsp_timeout} !== snap) begin
            unstable++;
          end
          if (cmd_ready) unstable++;
          if (rsp_ready) begin
            last_hs = cyc;
            if (exp_q.size() == 0) begin
              chk("unexpected_rsp", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_resp", rsp_resp, e.resp);
              chk("rsp_timeout", rsp_timeout, e.to);
              chk("rsp_latency", first_cyc - e.acc, e.lat);
              chk("rsp_stable_no_cmd_ready", unstable, 0);
            end
            seen = 0; chk_cr = 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_stats();
    aw_beats = 0; w_beats = 0; ar_beats = 0;
    n_awv = 0; n_wv = 0; n_arv = 0; n_bviol = 0; n_brdy = 0; n_bvld = 0;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc);
    logic done;
    done = 0; acc = -1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 200 && !done; i++) begin
      if (cmd_ready) begin acc = cyc; done = 1; end
      tick();
    end
    cmd_valid = 0;
    if (!done) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic expect_rsp(input logic [31:0] rd, input logic [1:0] rs, input logic to,
                            input int lat, input int acc);
    exp_t e;
    e.rdata = rd; e.resp = rs; e.to = to; e.lat = lat; e.acc = acc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300 && (exp_q.size() != 0 || rsp_valid); i++) tick();
    if (i == 300) chk("drain_timeout", 0, 1);
    tick();
  endtask

  initial begin : stim
    int acc, acc2, k;
    #12;
    chk("reset_ctrl_outputs", {cmd_ready, rsp_valid, rsp_timeout, axi.awvalid, axi.wvalid,
                               axi.bready, axi.arvalid, axi.rready}, 0);
    chk("reset_data_outputs", {rsp_rdata, rsp_resp, axi.awaddr, axi.araddr, axi.wstrb}, 0);
    chk("reset_wdata", axi.wdata, 0);
    @(posedge clk); #1 reset = 0;
    tick();
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // 1: immediate slave write
    clr_stats();
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_bresp = 2'b00;
    issue(1, 12'h010, 32'hA5A5_0001, 4'hF, acc);
    expect_rsp(32'h0, 2'b00, 0, 3, acc);
    drain();
    chk("t1_awaddr", got_awaddr, 12'h810);
    chk("t1_wdata", got_wdata, 32'hA5A5_0001);
    chk("t1_wstrb", got_wstrb, 4'hF);
    chk("t1_beats", {aw_beats[7:0], w_beats[7:0]}, 16'h0101);
    chk("t1_valid_cycles", {n_awv[7:0], n_wv[7:0]}, 16'h0101);

    // 2: read with 5 RVALID wait cycles
    clr_stats();
    cfg_ar_d = 0; cfg_r_d = 5; cfg_rdata = 32'h0000_CAFE; cfg_rresp = 2'b00;
    issue(0, 12'h000, 32'h0, 4'h0, acc);
    expect_rsp(32'h0000_CAFE, 2'b00, 0, 8, acc);
    drain();
    chk("t2_araddr", got_araddr, 12'h800);
    chk("t2_ar_beats", ar_beats, 1);
    chk("t2_arvalid_cycles", n_arv, 1);

    // 3: WREADY four cycles after AWREADY, SLVERR passed through
    clr_stats();
    cfg_aw_d = 0; cfg_w_d = 4; cfg_b_d = 0; cfg_bresp = 2'b10;
    issue(1, 12'h044, 32'h0BAD_F00D, 4'h5, acc);
    expect_rsp(32'h0, 2'b10, 0, 7, acc);
    drain();
    chk("t3_awvalid_cycles", n_awv, 1);
    chk("t3_wvalid_cycles", n_wv, 5);
    chk("t3_bready_early", n_bviol, 0);
    chk("t3_beats", {aw_beats[7:0], w_beats[7:0]}, 16'h0101);
    chk("t3_awaddr", got_awaddr, 12'h844);
    chk("t3_wstrb", got_wstrb, 4'h5);

    // 4: dead slave, timeout
    clr_stats();
    cfg_ar_d = 1000;
    issue(0, 12'h100, 32'h0, 4'h0, acc);
    expect_rsp(32'h0, 2'b10, 1, 17, acc);
    drain();
    chk("t4_arvalid_cycles", n_arv, TO);
    chk("t4_ar_beats", ar_beats, 0);
    chk("t4_rready_cycles", {axi.arvalid, axi.rready}, 0);

    // 5: response held off 10 cycles, second command queued behind it
    clr_stats();
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_bresp = 2'b00;
    cfg_ar_d = 0; cfg_r_d = 0; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
    rsp_ready = 0;
    issue(1, 12'h010, 32'h1234_5678, 4'h3, acc);
    expect_rsp(32'h0, 2'b00, 0, 3, acc);
    fork
      begin
        for (k = 0; k < 50 && !rsp_valid; k++) tick();
        repeat (10) tick();
        rsp_ready = 1;
      end
      begin
        issue(0, 12'h004, 32'h0, 4'h0, acc2);
        expect_rsp(32'hDEAD_BEEF, 2'b00, 0, 3, acc2);
      end
    join
    chk("t5_second_accept_cycle", acc2, last_hs + 1);
    drain();
    chk("t5_awaddr", got_awaddr, 12'h810);
    chk("t5_araddr", got_araddr, 12'h804);

    // 6: reset while waiting on B; stale BVALID must be ignored
    clr_stats();
    cfg_b_d = 8;
    issue(1, 12'h020, 32'h0000_0055, 4'hF, acc);
    for (k = 0; k < 50 && !axi.bready; k++) tick();
    chk("t6_reached_wr_resp", axi.bready, 1);
    #2 reset = 1;
    #1;
    chk("t6_async_reset_ctrl", {cmd_ready, rsp_valid, axi.awvalid, axi.wvalid, axi.bready,
                                axi.arvalid, axi.rready}, 0);
    chk("t6_async_reset_data", {axi.awaddr, axi.wdata, axi.wstrb}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 0;
    n_brdy = 0; n_bvld = 0;
    tick();
    chk("t6_cmd_ready_first_edge", cmd_ready, 1);
    repeat (12) tick();
    chk("t6_stale_b_not_accepted", n_brdy, 0);
    chk("t6_stale_b_presented", n_bvld > 0, 1);
    slv_clear = 1;
    cfg_b_d = 0;
    repeat (2) tick();

    // 7: recovery read after reset
    clr_stats();
    cfg_ar_d = 0; cfg_r_d = 0; cfg_rdata = 32'h0000_0042; cfg_rresp = 2'b01;
    issue(0, 12'h0FF, 32'h0, 4'h0, acc);
    expect_rsp(32'h0000_0042, 2'b01, 0, 3, acc);
    drain();
    chk("t7_araddr", got_araddr, 12'h8FF);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
